// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: memory-wait FSM with timeout, load-use interlock, redirect flush.
// Optional stall-cycle counter port stall_cnt exists only when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       cpu_clk,
    input  logic       cpu_rst,
    input  logic [4:0] id_rR1,
    input  logic [4:0] id_rR2,
    input  logic       id_re1,
    input  logic       id_re2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic       ex_rf_we,
    input  logic [4:0] ex_wR,
    input  logic       ex_br_taken,
    input  logic       mem_valid,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       suspend_pc,
    output logic       suspend_if_id,
    output logic       suspend_id_ex,
    output logic       suspend_ex_mem,
    output logic       suspend_mem_wb,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       mem_err
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_new_stall, mem_stall, redirect, load_use;

    assign mem_new_stall = mem_valid & mem_req & ~mem_ack;
    assign mem_stall     = mem_new_stall
                         | ((state_q == S_WAIT) & ~mem_ack)
                         | (state_q == S_ERR);
    assign redirect      = ex_valid & ex_br_taken;
    assign load_use      = ex_valid & ex_is_load & ex_rf_we & (ex_wR != 5'd0)
                         & ((id_re1 & (id_rR1 == ex_wR)) | (id_re2 & (id_rR2 == ex_wR)));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = 8'd0;
                if (mem_new_stall) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 8'd0;
                end else begin
                    // Saturating count; timeout fires on the cycle the count reaches TIMEOUT.
                    if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d >= TIMEOUT_C) state_d = S_ERR;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A redirect held in EX during a memory stall naturally re-presents itself once the stall drops.
    always_comb begin
        suspend_pc     = 1'b0;
        suspend_if_id  = 1'b0;
        suspend_id_ex  = 1'b0;
        suspend_ex_mem = 1'b0;
        suspend_mem_wb = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        if (mem_stall) begin
            suspend_pc     = 1'b1;
            suspend_if_id  = 1'b1;
            suspend_id_ex  = 1'b1;
            suspend_ex_mem = 1'b1;
            suspend_mem_wb = 1'b1;
        end else if (redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            suspend_pc    = 1'b1;
            suspend_if_id = 1'b1;
            flush_id_ex   = 1'b1;
        end
    end

    assign mem_err = (state_q == S_ERR);

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        any_suspend;

    assign any_suspend = suspend_pc | suspend_if_id | suspend_id_ex | suspend_ex_mem | suspend_mem_wb;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (any_suspend && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) stall_cnt_q <= 32'd0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TIMEOUT=4); expected output vectors go through a scoreboard queue.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       cpu_rst;
    logic [4:0] id_rR1, id_rR2, ex_wR;
    logic       id_re1, id_re2, ex_valid, ex_is_load, ex_rf_we, ex_br_taken;
    logic       mem_valid, mem_req, mem_ack;
    logic       suspend_pc, suspend_if_id, suspend_id_ex, suspend_ex_mem, suspend_mem_wb;
    logic       flush_if_id, flush_id_ex, mem_err;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] model_cnt = 32'd0;
`endif

    int total = 0;
    int bad   = 0;

    // Output vector: {spc, sifid, sidex, sexmem, smemwb, fifid, fidex, err}
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_LU    = 8'b1100_0010;
    localparam logic [7:0] O_STALL = 8'b1111_1000;
    localparam logic [7:0] O_RED   = 8'b0000_0110;
    localparam logic [7:0] O_ERR   = 8'b1111_1001;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(4)) dut (
        .cpu_clk        (clk),
        .cpu_rst        (cpu_rst),
        .id_rR1         (id_rR1),
        .id_rR2         (id_rR2),
        .id_re1         (id_re1),
        .id_re2         (id_re2),
        .ex_valid       (ex_valid),
        .ex_is_load     (ex_is_load),
        .ex_rf_we       (ex_rf_we),
        .ex_wR          (ex_wR),
        .ex_br_taken    (ex_br_taken),
        .mem_valid      (mem_valid),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .suspend_pc     (suspend_pc),
        .suspend_if_id  (suspend_if_id),
        .suspend_id_ex  (suspend_id_ex),
        .suspend_ex_mem (suspend_ex_mem),
        .suspend_mem_wb (suspend_mem_wb),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .mem_err        (mem_err)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic idle_in();
        id_rR1 = 5'd0; id_rR2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rf_we = 1'b0; ex_wR = 5'd0; ex_br_taken = 1'b0;
        mem_valid = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; checks just before the next rising edge.
    task automatic cyc(input logic [7:0] e, input string t);
        logic [7:0] obs, ex;
        string      tg;
        exp_q.push_back(e);
        tag_q.push_back(t);
        #4;
        obs = {suspend_pc, suspend_if_id, suspend_id_ex, suspend_ex_mem, suspend_mem_wb,
               flush_if_id, flush_id_ex, mem_err};
        ex = exp_q.pop_front();
        tg = tag_q.pop_front();
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tg, obs, ex);
        end
        $display("t=%0t %s observed=%b expected=%b", $time, tg, obs, ex);
`ifdef PIPE_CTRL_PERF_CNT_EN
        total++;
        assert (stall_cnt === model_cnt) else begin
            bad++;
            $error("FAIL %s_cnt observed=%0d expected=%0d", tg, stall_cnt, model_cnt);
        end
        if (cpu_rst) model_cnt = 32'd0;
        else if (|ex[7:3]) model_cnt = model_cnt + 32'd1;
`endif
        @(negedge clk);
    endtask

    initial begin
        idle_in();
        cpu_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc(O_NONE, "reset");
        cpu_rst = 1'b0;
        cyc(O_NONE, "idle");

        // Load-use on rR2, single cycle
        ex_valid = 1; ex_is_load = 1; ex_rf_we = 1; ex_wR = 5'd5; id_rR2 = 5'd5; id_re2 = 1;
        cyc(O_LU, "lu_rR2");
        idle_in();
        cyc(O_NONE, "lu_gone");
        // Load-use on rR1, then gated variants
        ex_valid = 1; ex_is_load = 1; ex_rf_we = 1; ex_wR = 5'd7; id_rR1 = 5'd7; id_re1 = 1;
        cyc(O_LU, "lu_rR1");
        id_re1 = 0;
        cyc(O_NONE, "lu_no_re");
        id_re1 = 1; ex_is_load = 0;
        cyc(O_NONE, "lu_not_load");
        ex_is_load = 1; ex_rf_we = 0;
        cyc(O_NONE, "lu_no_we");
        ex_rf_we = 1; id_rR1 = 5'd6;
        cyc(O_NONE, "lu_no_match");
        // x0 never hazards
        ex_wR = 5'd0; id_rR1 = 5'd0; id_rR2 = 5'd0; id_re2 = 1;
        cyc(O_NONE, "lu_x0");
        idle_in();

        // Redirect
        ex_valid = 1; ex_br_taken = 1;
        cyc(O_RED, "redirect");
        ex_valid = 0;
        cyc(O_NONE, "redirect_invalid");
        // Redirect beats load-use
        ex_valid = 1; ex_is_load = 1; ex_rf_we = 1; ex_wR = 5'd9; id_rR1 = 5'd9; id_re1 = 1;
        cyc(O_RED, "redirect_over_lu");
        idle_in();

        // Same-cycle ack: no stall, stays IDLE
        mem_valid = 1; mem_req = 1; mem_ack = 1;
        cyc(O_NONE, "ack_same_cycle");
        mem_req = 0; mem_ack = 0;
        cyc(O_NONE, "ack_same_after");
        mem_valid = 0; mem_req = 1;
        cyc(O_NONE, "req_not_valid");
        idle_in();

        // Three-cycle memory wait
        mem_valid = 1; mem_req = 1;
        for (int i = 0; i < 3; i++) cyc(O_STALL, $sformatf("mem_wait%0d", i));
        mem_ack = 1;
        cyc(O_NONE, "mem_ack");
        idle_in();
        cyc(O_NONE, "mem_idle_after");

        // Redirect deferred across a 2-cycle stall
        ex_valid = 1; ex_br_taken = 1; mem_valid = 1; mem_req = 1;
        for (int i = 0; i < 2; i++) cyc(O_STALL, $sformatf("defer_stall%0d", i));
        mem_ack = 1;
        cyc(O_RED, "defer_redirect");
        idle_in();

        // Load-use hidden under a stall
        ex_valid = 1; ex_is_load = 1; ex_rf_we = 1; ex_wR = 5'd3; id_rR2 = 5'd3; id_re2 = 1;
        mem_valid = 1; mem_req = 1;
        cyc(O_STALL, "lu_under_stall");
        ex_valid = 0; ex_is_load = 0; ex_rf_we = 0; id_re2 = 0;
        mem_ack = 1;
        cyc(O_NONE, "lu_stall_ack");
        idle_in();

        // Timeout: one IDLE stall cycle plus four WAIT cycles, then ERR
        mem_valid = 1; mem_req = 1;
        for (int i = 0; i < 5; i++) cyc(O_STALL, $sformatf("to_wait%0d", i));
        cyc(O_ERR, "to_err");
        mem_ack = 1;
        cyc(O_ERR, "err_sticky_ack");
        idle_in();
        ex_valid = 1; ex_br_taken = 1;
        cyc(O_ERR, "err_over_redirect");
        idle_in();
        cpu_rst = 1;
        cyc(O_ERR, "err_rst_cycle");
        cpu_rst = 0;
        cyc(O_NONE, "err_cleared");

        // Reset aborts an in-flight WAIT
        mem_valid = 1; mem_req = 1;
        for (int i = 0; i < 2; i++) cyc(O_STALL, $sformatf("abort_wait%0d", i));
        idle_in();
        cpu_rst = 1;
        cyc(O_STALL, "wait_rst_cycle");
        cpu_rst = 0;
        cyc(O_NONE, "wait_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, range 1..255: maximum consecutive cycles of memory wait before error.
REQ-002 cpu_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 cpu_rst  in  1  reset, synchronous, active-high.
REQ-004 id_rR1, id_rR2  in  5 each  ID-stage source register numbers.
REQ-005 id_re1, id_re2  in  1 each  ID-stage source register read enables.
REQ-006 ex_valid, ex_is_load, ex_rf_we  in  1 each  EX-stage valid, load-type instruction, register write enable.
REQ-007 ex_wR  in  5  EX-stage destination register.
REQ-008 ex_br_taken  in  1  EX-stage redirect (taken branch or jump).
REQ-009 mem_valid, mem_req, mem_ack  in  1 each  MEM-stage valid, data-RAM access request, data-RAM ready.
REQ-010 suspend_pc, suspend_if_id, suspend_id_ex, suspend_ex_mem, suspend_mem_wb  out  1 each  hold PC and each pipeline register.
REQ-011 flush_if_id, flush_id_ex  out  1 each  load a bubble (valid=0) into that register next edge.
REQ-012 mem_err  out  1  sticky memory-timeout error.
REQ-013 stall_cnt  out  32  stall-cycle counter (only when PERF_CNT_EN is defined).

Function
REQ-014 All suspend/flush outputs SHALL be combinational from current inputs and registered state (zero latency).
REQ-015 mem_stall = mem_valid & mem_req & ~mem_ack, or state WAIT with ~mem_ack, or state ERR.
REQ-016 mem_stall SHALL assert all five suspend outputs and deassert both flushes.
REQ-017 FSM states IDLE, WAIT, ERR; IDLE->WAIT on mem_valid & mem_req & ~mem_ack; WAIT->IDLE on mem_ack; WAIT->ERR when wait_cnt reaches TIMEOUT with ~mem_ack; ERR exits only on reset.
REQ-018 Request acked in the same cycle it is raised SHALL cause no stall and no state change.
REQ-019 wait_cnt (8-bit) SHALL clear in IDLE, increment each WAIT cycle, never wrap.
REQ-020 mem_err SHALL be 1 exactly while in ERR.
REQ-021 Load-use hazard = ex_valid & ex_is_load & ex_rf_we & ex_wR!=0 & ((id_re1 & id_rR1==ex_wR) | (id_re2 & id_rR2==ex_wR)).
REQ-022 Load-use without mem_stall or redirect SHALL assert suspend_pc, suspend_if_id and flush_id_ex only, for exactly that cycle.
REQ-023 Redirect = ex_valid & ex_br_taken; without mem_stall SHALL assert flush_if_id and flush_id_ex, no suspends.
REQ-024 Priority: mem_stall > redirect > load-use; redirect during mem_stall SHALL be deferred (EX held) and take effect the first cycle mem_stall drops.
REQ-025 Register x0 (ex_wR=0) SHALL never create a hazard.

Reset
REQ-026 While cpu_rst=1: state=IDLE, wait_cnt=0, mem_err=0, stall_cnt=0 on next edge; reset SHALL override any in-flight WAIT or ERR.
REQ-027 During reset cycle suspend/flush outputs SHALL follow REQ-014 from inputs; after reset all outputs 0 with idle inputs.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_CNT_EN: defined -> stall_cnt increments each cycle any suspend output is 1, saturating at 32'hFFFF_FFFF; undefined -> port stall_cnt and its register SHALL not exist, all other behaviour identical.

Verification
REQ-029 Load x5 in EX, ID reads x5 on rR2 with re2=1 -> one cycle suspend_pc=suspend_if_id=flush_id_ex=1, others 0.
REQ-030 Load x0 in EX, ID reads x0 -> all outputs 0.
REQ-031 mem_req with mem_ack low 3 cycles then high -> all suspends 1 for 3 cycles, state IDLE after, stall_cnt=3 (macro defined).
REQ-032 TIMEOUT=4, mem_ack never rises -> mem_err=1 after wait_cnt reaches 4, suspends stay 1; cpu_rst pulse -> mem_err=0, IDLE.
REQ-033 ex_br_taken during 2-cycle mem stall -> no flush during stall; flush_if_id=flush_id_ex=1 on first cycle after ack.
REQ-034 Redirect and load-use same cycle -> flush_if_id=flush_id_ex=1, suspend_pc=0.
